// File: rtl/logic_seq_pkg.sv
// Shared types and helpers for the bit-serial logic sequencer.
// Opcodes 4-7 are illegal; is_legal_op is the single place that decides that.
package logic_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOT = 3'd3
  } logic_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/logic_bit_cell.sv
// Combinational 1-bit logic cell: AND/OR/XOR/NOT(a) selected by a 3-bit opcode.
// Illegal opcodes produce 0 so the result register never sees X or Z.
module logic_bit_cell
  import logic_seq_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic [2:0] i_op,
  output logic       o_y
);

  always_comb begin
    o_y = 1'b0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_NOT:  o_y = ~i_a;
      default: o_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_seq_ctrl.sv
// Bit-serial sequencer: accepts an operand pair and opcode, runs it LSB-first
// through logic_bit_cell and presents the assembled word. Optional LOGSEQ_PARITY_EN
// adds out_parity (XOR of all result bits, accumulated serially).
module logic_seq_ctrl
  import logic_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer holds in_* stable while in_valid && !in_ready; the result
  // and error flag stay stable while out_valid && !out_ready.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic             busy,
`ifdef LOGSEQ_PARITY_EN
  output logic             out_parity,
`endif
  output logic [1:0]       dbg_state
);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_err;
  logic             w_bit;
  logic             w_last;
`ifdef LOGSEQ_PARITY_EN
  logic             r_parity;
`endif

  logic_bit_cell u_cell (
    .i_a  (r_a_sh[0]),
    .i_b  (r_b_sh[0]),
    .i_op (r_op),
    .o_y  (w_bit)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = is_legal_op(in_op) ? S_RUN : S_DONE;
      S_RUN:  if (w_last)   w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
`ifdef LOGSEQ_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh   <= in_a;
            r_b_sh   <= in_b;
            r_op     <= in_op;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= ~is_legal_op(in_op);
`ifdef LOGSEQ_PARITY_EN
            r_parity <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          r_result[r_cnt] <= w_bit;
          r_a_sh          <= r_a_sh >> 1;
          r_b_sh          <= r_b_sh >> 1;
          // Hold at WIDTH-1 rather than wrapping; the next acceptance clears it.
          if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
`ifdef LOGSEQ_PARITY_EN
          r_parity <= r_parity ^ w_bit;
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;
  assign out_err    = r_err;
  assign dbg_state  = r_state;
`ifdef LOGSEQ_PARITY_EN
  assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_logic_seq_ctrl.sv
// Self-checking bench for logic_seq_ctrl: directed scenarios plus a random
// back-to-back run, with expected words queued at acceptance and popped at output.
module tb_logic_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int CLK_P = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic             busy;
  logic             out_parity;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             exp_err_q[$];
  logic             exp_par_q[$];
  time              acc_time;

  logic_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy),
`ifdef LOGSEQ_PARITY_EN
    .out_parity (out_parity),
`endif
    .dbg_state  (dbg_state)
  );

`ifndef LOGSEQ_PARITY_EN
  assign out_parity = 1'b0;
`endif

  always #(CLK_P / 2) clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      default: return '0;
    endcase
  endfunction

  // Drive a request, wait (bounded) for acceptance, push the expectation.
  // Returns at 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, output bit ok);
    logic [WIDTH-1:0] r;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        acc_time = $time;
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the latched request must be unaffected.
    in_op = 3'($urandom_range(0, 7));
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    if (ok) begin
      r = model(op, a, b);
      exp_q.push_back(r);
      exp_err_q.push_back(op > 3'd3);
      exp_par_q.push_back(^r);
    end
  endtask

  // Wait (bounded) for out_valid; lat counts cycles from the accepting cycle.
  // Returns at a falling edge with out_valid high when ok.
  task automatic wait_out(output int lat, output bit ok);
    ok = 1'b0;
    lat = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_result !== '0 || out_err !== 1'b0 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h err=%b par=%b required 1 0 0 00 0 0",
               in_ready, out_valid, busy, out_result, out_err, out_parity);
    end
  endtask

  // One full legal/illegal transaction with latency, result, err and parity checks.
  task automatic test_single(input string name, input logic [2:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    int lat;
    int exp_lat;
    logic [WIDTH-1:0] er;
    logic ee, ep;
    exp_lat = (op > 3'd3) ? 1 : WIDTH + 1;
    send(op, a, b, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: request not accepted within bound", name);
      return;
    end
    wait_out(lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s out_valid: never rose within bound", name);
      return;
    end
    er = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    ep = exp_par_q.pop_front();
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_result !== er || out_err !== ee) begin
      errors++;
      $display("FAIL %s result: got %h err %b required %h err %b", name, out_result, out_err, er, ee);
    end
`ifdef LOGSEQ_PARITY_EN
    checks++;
    if (out_parity !== ep) begin
      errors++;
      $display("FAIL %s parity: got %b required %b", name, out_parity, ep);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [WIDTH-1:0] er;
    out_ready = 1'b0;
    send(3'd2, 8'hA5, 8'hFF, ok);
    wait_out(lat, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp out_valid: never rose within bound");
      out_ready = 1'b1;
      return;
    end
    er = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    void'(exp_par_q.pop_front());
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== er || out_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp hold cycle %0d: valid=%b result=%h err=%b in_ready=%b required 1 %h 0 0",
                 c, out_valid, out_result, out_err, in_ready, er);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp handshake cycle: in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp after handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    send(3'd0, 8'hAA, 8'hFF, ok);
    exp_q.delete();
    exp_err_q.delete();
    exp_par_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_result !== '0 || out_err !== 1'b0 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL mid-run reset: busy=%b in_ready=%b out_valid=%b result=%h err=%b required 0 1 0 00 0",
               busy, in_ready, out_valid, out_result, out_err);
    end
    test_single("after_reset_and", 3'd0, 8'hFF, 8'h0F);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    time prev_t;
    logic [2:0] prev_op;
    logic [2:0] op;
    logic [WIDTH-1:0] er;
    logic ee, ep;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      send(op, WIDTH'($urandom), WIDTH'($urandom), ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL b2b accept %0d: not accepted within bound", i);
        return;
      end
      if (i > 0) begin
        checks++;
        if (acc_time - prev_t !== time'(((prev_op > 3'd3) ? 2 : WIDTH + 2) * CLK_P)) begin
          errors++;
          $display("FAIL b2b spacing %0d: got %0t required %0d cycles", i, acc_time - prev_t,
                   (prev_op > 3'd3) ? 2 : WIDTH + 2);
        end
      end
      prev_t = acc_time;
      prev_op = op;
      wait_out(lat, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b out_valid %0d: never rose within bound", i);
        return;
      end
      er = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      ep = exp_par_q.pop_front();
      checks++;
      if (out_result !== er || out_err !== ee) begin
        errors++;
        $display("FAIL b2b result %0d op %0d: got %h err %b required %h err %b", i, op, out_result, out_err, er, ee);
      end
`ifdef LOGSEQ_PARITY_EN
      checks++;
      if (out_parity !== ep) begin
        errors++;
        $display("FAIL b2b parity %0d: got %b required %b", i, out_parity, ep);
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single("and", 3'd0, 8'hF0, 8'hCC);
    test_backpressure();
    test_single("not", 3'd3, 8'h3C, 8'hFF);
    test_single("or", 3'd1, 8'h01, 8'h80);
    test_single("illegal", 3'd6, 8'hFF, 8'hFF);
    test_single("legal_after_illegal", 3'd2, 8'h0F, 8'h33);
    test_single("and_parity", 3'd0, 8'hFF, 8'h07);
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
